rcn_master: RTL
===============

# rcn_master

Single-client request initiator for the rcn ring, sitting upstream of `rcn_slave` stages. It accepts one-word read/write requests from local logic and inserts them into empty ring slots. It tracks up to four outstanding transactions by 2-bit sequence tag and removes its own responses from the ring, returning read data to the client. All other ring traffic passes through with fixed two-register latency.

## Interface
- `MASTER_ID`, default 1: 6-bit ring ID placed in request bits [65:60] and matched on responses.
- `TIMEOUT_CYCLES`, default 255: 8-bit age limit per outstanding tag; used only with `RCN_MASTER_TIMEOUT_EN`.
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: reset, synchronous active-high.
- `rcn_in` in 69: ring input from the previous stage.
- `rcn_out` out 69: ring output to the next stage, registered.
- `cs` in 1: request strobe; accepted when `busy`=0.
- `wr` in 1: 1=write, 0=read.
- `mask` in 4: byte enables.
- `addr` in 24: byte address; bits [1:0] ignored.
- `wdata` in 32: write data; ignored for reads.
- `busy` out 1: request not accepted this cycle.
- `rsp_vld` out 1: one-cycle response pulse.
- `rsp_wr` out 1: response is for a write.
- `rsp_seq` out 2: tag of the responding transaction.
- `rsp_data` out 32: read data; don't-care for writes.
- `timeout_err` out 1: one-cycle pulse when a tag is aged out. Tied 0 without the macro.

## Operation
- Ring word fields:
  - [68] valid.
  - [67] 1=request, 0=response.
  - [66] wr.
  - [65:60] master ID.
  - [59:56] mask.
  - [55:34] addr[23:2].
  - [33:32] seq.
  - [31:0] data.
- Input register `rin` <= `rcn_in` every cycle.
- Per-cycle slot decision on `rin`, in priority order:
  1. **Own response** (valid, !req, ID==`MASTER_ID`): consume. `rsp_*` are registered from `rin`. The tag is freed and the slot is treated as empty.
  2. **Other valid traffic**: `rout` <= `rin` unchanged.
  3. **Empty slot** with a request held: `rout` <= request word (valid=1, req=1). The hold register clears.
  4. Otherwise `rout` <= 0.
- A slot freed by rule 1 may be filled by rule 3 in the same cycle.
- **Request hold**: one entry. On `cs && !busy`, capture `wr`, `mask`, `addr[23:2]`, `wdata` and seq=`next_seq`. `next_seq` then increments mod 4.
- **Outstanding count** `ocnt` (0..4):
  - +1 on accept.
  - −1 on own-response consume or timeout.
  - Simultaneous +1/−1 leaves it unchanged.
- `busy` = hold full OR `ocnt`==4. It is combinational from registered state only, never from `cs`.
- Every request, read or write, consumes a tag until its response returns.
- A response whose tag is not outstanding is still consumed and reported. It does not decrement `ocnt` below 0.
- Responses may return out of order. The client matches them on `rsp_seq`.
- **Reset**: `rin`, `rout`, hold, `ocnt`, `next_seq` and ages are cleared. `busy`=0, `rsp_vld`=0, `rsp_*`=0, `timeout_err`=0.
- Reset mid-transaction discards all outstanding tags. Late responses after reset are consumed and reported as unmatched.

## Timing
- Accept in cycle N: `busy`=1 from N+1 until hold clears.
- Earliest on `rcn_out`: cycle N+2, if `rin` is empty in N+1.
- Pass-through latency `rcn_in`→`rcn_out`: 2 cycles.
- Own response on `rcn_in` in cycle M: `rin` in M+1, `rsp_vld` high in M+2 for exactly one cycle.
- Back-to-back responses produce back-to-back `rsp_vld` pulses.
- Insertion waits indefinitely under continuous foreign traffic; there is no fairness guarantee.

## Configuration
- `RCN_MASTER_TIMEOUT_EN` defined:
  - Each outstanding tag has an 8-bit age counter, incremented every cycle.
  - At `TIMEOUT_CYCLES` the tag is freed, `ocnt` decrements and `timeout_err` pulses for one cycle.
  - A later response for that tag is reported as unmatched.
- Macro undefined: no age counters, `timeout_err`=0, tags freed only by responses.

## Test plan
- Idle ring, read `addr`=0x000104, `mask`=0xF at cycle 0 → `rcn_out` in cycle 2 = {1,1,0,ID,F,0x41,0,0}. Looped-back response data 0xDEADBEEF → `rsp_vld` with `rsp_data`=0xDEADBEEF, `rsp_seq`=0.
- Issue 4 requests with no responses → `busy` stays 1 after the fourth. One response frees a tag → `busy` drops, and the next request gets seq=0 (wrap).
- Continuous foreign valid words on `rcn_in` → all forwarded unchanged with 2-cycle delay and the held request is not inserted. First empty slot → request inserted.
- Own response immediately followed by an empty slot, with a request held → response consumed, request inserted into the freed slot the same cycle, `rsp_vld`=1.
- Responses returning in order 2,0,1 → `rsp_seq` sequence 2,0,1 and `ocnt` returns to 0.
- `RCN_MASTER_TIMEOUT_EN` on, `TIMEOUT_CYCLES`=10, no response → `timeout_err` pulses 10 cycles after insertion and `ocnt` returns to 0. Assert `rst` with 3 outstanding → `ocnt`=0 and `busy`=0 on the next cycle.

Source files
------------

// File: rtl/rcn_master.sv
// rcn_master: single-client request initiator for the rcn ring.
// Inserts one-word requests into empty ring slots, tracks up to four
// outstanding tags, removes its own responses and forwards every other
// ring word with two-register latency.
// Optional per-tag timeout: define RCN_MASTER_TIMEOUT_EN.
module rcn_master #(
    parameter logic [5:0] MASTER_ID      = 6'd1,
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [68:0] rcn_in,
    output logic [68:0] rcn_out,
    input  logic        cs,
    input  logic        wr,
    input  logic [3:0]  mask,
    input  logic [23:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        rsp_vld,
    output logic        rsp_wr,
    output logic [1:0]  rsp_seq,
    output logic [31:0] rsp_data,
    output logic        timeout_err
);

    logic [68:0] rin_q, rin_d;
    logic [68:0] rout_q, rout_d;
    logic        hold_vld_q, hold_vld_d;
    logic [68:0] hold_q, hold_d;
    logic [3:0]  pend_q, pend_d;
    logic [2:0]  ocnt_q, ocnt_d;
    logic [1:0]  next_seq_q, next_seq_d;
    logic        rsp_vld_q, rsp_vld_d;
    logic        rsp_wr_q, rsp_wr_d;
    logic [1:0]  rsp_seq_q, rsp_seq_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        timeout_err_q, timeout_err_d;

    logic        own_rsp;
    logic        slot_free;
    logic        insert;
    logic        accept;
    logic [3:0]  rsp_free;
    logic [3:0]  expire;

    function automatic logic [68:0] make_req(input logic        w,
                                             input logic [3:0]  m,
                                             input logic [21:0] a,
                                             input logic [1:0]  s,
                                             input logic [31:0] d);
        make_req = {1'b1, 1'b1, w, MASTER_ID, m, a, s, d};
    endfunction

    function automatic logic [2:0] count4(input logic [3:0] v);
        count4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    // A consumed own response leaves an empty slot that the held request may take.
    assign own_rsp   = rin_q[68] && !rin_q[67] && (rin_q[65:60] == MASTER_ID);
    assign slot_free = !rin_q[68] || own_rsp;
    assign insert    = slot_free && hold_vld_q;
    assign busy      = hold_vld_q || (ocnt_q == 3'd4);
    assign accept    = cs && !busy;
    assign rsp_free  = own_rsp ? (4'b0001 << rin_q[33:32]) : 4'b0000;

`ifdef RCN_MASTER_TIMEOUT_EN
    logic [3:0]      live_q, live_d;
    logic [3:0][7:0] age_q, age_d;
    logic            unused_bits;
    assign unused_bits = ^addr[1:0];

    // Ages count from the cycle the request appears on rcn_out.
    always_comb begin
        expire = 4'b0000;
        age_d  = age_q;
        for (int t = 0; t < 4; t++) begin
            if (live_q[t] && (age_q[t] == TIMEOUT_CYCLES - 8'd1)) expire[t] = 1'b1;
            if (live_q[t]) age_d[t] = age_q[t] + 8'd1;
        end
        live_d = live_q & ~rsp_free & ~expire;
        if (insert) begin
            live_d[hold_q[33:32]] = 1'b1;
            age_d[hold_q[33:32]]  = 8'd0;
        end
    end

    // Age counter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            live_q <= 4'b0000;
            age_q  <= '0;
        end else begin
            live_q <= live_d;
            age_q  <= age_d;
        end
    end
`else
    logic unused_bits;
    assign unused_bits = ^{addr[1:0], TIMEOUT_CYCLES};
    assign expire      = 4'b0000;
`endif

    // Slot decision, request hold, tag bookkeeping and response capture.
    always_comb begin
        rin_d = rcn_in;
        if (rin_q[68] && !own_rsp) begin
            rout_d = rin_q;
        end else if (hold_vld_q) begin
            rout_d = hold_q;
        end else begin
            rout_d = '0;
        end

        hold_vld_d = hold_vld_q;
        hold_d     = hold_q;
        if (insert) hold_vld_d = 1'b0;
        if (accept) begin
            hold_vld_d = 1'b1;
            hold_d     = make_req(wr, mask, addr[23:2], next_seq_q, wdata);
        end
        next_seq_d = accept ? next_seq_q + 2'd1 : next_seq_q;

        // An unmatched response clears nothing, so the count cannot underflow.
        pend_d = pend_q & ~rsp_free & ~expire;
        if (accept) pend_d[next_seq_q] = 1'b1;
        ocnt_d = count4(pend_d);

        rsp_vld_d  = own_rsp;
        rsp_wr_d   = rsp_wr_q;
        rsp_seq_d  = rsp_seq_q;
        rsp_data_d = rsp_data_q;
        if (own_rsp) begin
            rsp_wr_d   = rin_q[66];
            rsp_seq_d  = rin_q[33:32];
            rsp_data_d = rin_q[31:0];
        end
        timeout_err_d = |expire;
    end

    // All registered state.
    always_ff @(posedge clk) begin
        if (rst) begin
            rin_q         <= '0;
            rout_q        <= '0;
            hold_vld_q    <= 1'b0;
            hold_q        <= '0;
            pend_q        <= 4'b0000;
            ocnt_q        <= 3'd0;
            next_seq_q    <= 2'd0;
            rsp_vld_q     <= 1'b0;
            rsp_wr_q      <= 1'b0;
            rsp_seq_q     <= 2'd0;
            rsp_data_q    <= 32'd0;
            timeout_err_q <= 1'b0;
        end else begin
            rin_q         <= rin_d;
            rout_q        <= rout_d;
            hold_vld_q    <= hold_vld_d;
            hold_q        <= hold_d;
            pend_q        <= pend_d;
            ocnt_q        <= ocnt_d;
            next_seq_q    <= next_seq_d;
            rsp_vld_q     <= rsp_vld_d;
            rsp_wr_q      <= rsp_wr_d;
            rsp_seq_q     <= rsp_seq_d;
            rsp_data_q    <= rsp_data_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign rcn_out     = rout_q;
    assign rsp_vld     = rsp_vld_q;
    assign rsp_wr      = rsp_wr_q;
    assign rsp_seq     = rsp_seq_q;
    assign rsp_data    = rsp_data_q;
    assign timeout_err = timeout_err_q;

endmodule
